// File: rtl/pe_pass_controller.sv
// Pass sequencer for one PE wrapper: latches the pass configuration, pulses configure,
// meters source words into the PE FIFOs, drains opsum words, then waits for the PE to go idle.
module pe_pass_controller #(
    parameter int S_WIDTH   = 4,
    parameter int F_WIDTH   = 6,
    parameter int U_WIDTH   = 3,
    parameter int n_WIDTH   = 3,
    parameter int p_WIDTH   = 5,
    parameter int q_WIDTH   = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [S_WIDTH-1:0]   cfg_S,
    input  logic [F_WIDTH-1:0]   cfg_F,
    input  logic [U_WIDTH-1:0]   cfg_U,
    input  logic [n_WIDTH-1:0]   cfg_n,
    input  logic [p_WIDTH-1:0]   cfg_p,
    input  logic [q_WIDTH-1:0]   cfg_q,
    input  logic [CNT_WIDTH-1:0] n_filter,
    input  logic [CNT_WIDTH-1:0] n_ifmap,
    input  logic [CNT_WIDTH-1:0] n_ipsum,
    input  logic [CNT_WIDTH-1:0] n_opsum,
    output logic                 ctrl_busy,
    output logic                 done,
    output logic                 pe_enable,
    output logic                 pe_configure,
    output logic [S_WIDTH-1:0]   pe_S,
    output logic [F_WIDTH-1:0]   pe_F,
    output logic [U_WIDTH-1:0]   pe_U,
    output logic [n_WIDTH-1:0]   pe_n,
    output logic [p_WIDTH-1:0]   pe_p,
    output logic [q_WIDTH-1:0]   pe_q,
    input  logic                 pe_busy,
    input  logic                 filter_valid,
    output logic                 filter_ready,
    output logic                 push_filter,
    input  logic                 filter_fifo_full,
    input  logic                 ifmap_valid,
    output logic                 ifmap_ready,
    output logic                 push_ifmap,
    input  logic                 ifmap_fifo_full,
    input  logic                 ipsum_valid,
    output logic                 ipsum_ready,
    output logic                 push_ipsum,
    input  logic                 ipsum_fifo_full,
    input  logic                 opsum_fifo_empty,
    output logic                 pop_opsum,
    output logic                 opsum_valid,
    input  logic                 opsum_ready
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONFIG  = 3'd1,
        ST_STREAM  = 3'd2,
        ST_WAIT_PE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_f_q, cnt_i_q, cnt_p_q, cnt_o_q;
    logic [CNT_WIDTH-1:0] cnt_f_d, cnt_i_d, cnt_p_d, cnt_o_d;
    logic [CNT_WIDTH-1:0] tot_f_q, tot_i_q, tot_p_q, tot_o_q;
    logic [S_WIDTH-1:0]   pe_S_q;
    logic [F_WIDTH-1:0]   pe_F_q;
    logic [U_WIDTH-1:0]   pe_U_q;
    logic [n_WIDTH-1:0]   pe_n_q;
    logic [p_WIDTH-1:0]   pe_p_q;
    logic [q_WIDTH-1:0]   pe_q_q;
    logic                 pe_enable_q, pe_configure_q, done_q;

    logic stream_s, push_f_s, push_i_s, push_p_s, opsum_valid_s, pop_o_s, all_done_s;

    // Channel handshakes; abort kills every transfer in the cycle it is seen.
    always_comb begin
        stream_s      = (state_q == ST_STREAM) && !abort;
        push_f_s      = stream_s && filter_valid && !filter_fifo_full && (cnt_f_q < tot_f_q);
        push_i_s      = stream_s && ifmap_valid  && !ifmap_fifo_full  && (cnt_i_q < tot_i_q);
        push_p_s      = stream_s && ipsum_valid  && !ipsum_fifo_full  && (cnt_p_q < tot_p_q);
        opsum_valid_s = stream_s && !opsum_fifo_empty && (cnt_o_q < tot_o_q);
        pop_o_s       = opsum_valid_s && opsum_ready;
        cnt_f_d       = cnt_f_q + CNT_WIDTH'(push_f_s);
        cnt_i_d       = cnt_i_q + CNT_WIDTH'(push_i_s);
        cnt_p_d       = cnt_p_q + CNT_WIDTH'(push_p_s);
        cnt_o_d       = cnt_o_q + CNT_WIDTH'(pop_o_s);
        all_done_s    = (cnt_f_q == tot_f_q) && (cnt_i_q == tot_i_q) &&
                        (cnt_p_q == tot_p_q) && (cnt_o_q == tot_o_q);
    end

    // Pass FSM with counters, latched pass configuration and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cnt_f_q        <= '0;
            cnt_i_q        <= '0;
            cnt_p_q        <= '0;
            cnt_o_q        <= '0;
            tot_f_q        <= '0;
            tot_i_q        <= '0;
            tot_p_q        <= '0;
            tot_o_q        <= '0;
            pe_S_q         <= '0;
            pe_F_q         <= '0;
            pe_U_q         <= '0;
            pe_n_q         <= '0;
            pe_p_q         <= '0;
            pe_q_q         <= '0;
            pe_enable_q    <= 1'b0;
            pe_configure_q <= 1'b0;
            done_q         <= 1'b0;
        end else if (abort && (state_q != ST_IDLE)) begin
            state_q        <= ST_IDLE;
            cnt_f_q        <= '0;
            cnt_i_q        <= '0;
            cnt_p_q        <= '0;
            cnt_o_q        <= '0;
            pe_enable_q    <= 1'b0;
            pe_configure_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        tot_f_q        <= n_filter;
                        tot_i_q        <= n_ifmap;
                        tot_p_q        <= n_ipsum;
                        tot_o_q        <= n_opsum;
                        pe_S_q         <= cfg_S;
                        pe_F_q         <= cfg_F;
                        pe_U_q         <= cfg_U;
                        pe_n_q         <= cfg_n;
                        pe_p_q         <= cfg_p;
                        pe_q_q         <= cfg_q;
                        pe_configure_q <= 1'b1;
                        pe_enable_q    <= 1'b1;
                        state_q        <= ST_CONFIG;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CONFIG: begin
                    pe_configure_q <= 1'b0;
                    pe_enable_q    <= 1'b1;
                    state_q        <= ST_STREAM;
                end
                ST_STREAM: begin
                    cnt_f_q <= cnt_f_d;
                    cnt_i_q <= cnt_i_d;
                    cnt_p_q <= cnt_p_d;
                    cnt_o_q <= cnt_o_d;
                    // Completion is judged on the registered counts, so the final
                    // transfer is followed by one more STREAM cycle.
                    if (all_done_s) begin
                        state_q <= ST_WAIT_PE;
                    end else begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_WAIT_PE: begin
                    if (!pe_busy) begin
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        pe_enable_q <= 1'b0;
                        cnt_f_q     <= '0;
                        cnt_i_q     <= '0;
                        cnt_p_q     <= '0;
                        cnt_o_q     <= '0;
                    end else begin
                        state_q <= ST_WAIT_PE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q        <= ST_IDLE;
                    pe_enable_q    <= 1'b0;
                    pe_configure_q <= 1'b0;
                    done_q         <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping.
    always_comb begin
        ctrl_busy    = (state_q != ST_IDLE);
        done         = done_q;
        pe_enable    = pe_enable_q;
        pe_configure = pe_configure_q;
        pe_S         = pe_S_q;
        pe_F         = pe_F_q;
        pe_U         = pe_U_q;
        pe_n         = pe_n_q;
        pe_p         = pe_p_q;
        pe_q         = pe_q_q;
        push_filter  = push_f_s;
        filter_ready = push_f_s;
        push_ifmap   = push_i_s;
        ifmap_ready  = push_i_s;
        push_ipsum   = push_p_s;
        ipsum_ready  = push_p_s;
        opsum_valid  = opsum_valid_s;
        pop_opsum    = pop_o_s;
    end

endmodule

// File: tb/tb_pe_pass_controller.sv
// Directed plus randomized bench for pe_pass_controller, checked against a word-count
// model of one pass (remaining words per channel, pass phases timed from start).
module tb_pe_pass_controller;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0, abort = 1'b0;
    logic [3:0]    cfg_S = '0;
    logic [5:0]    cfg_F = '0;
    logic [2:0]    cfg_U = '0, cfg_n = '0, cfg_q = '0;
    logic [4:0]    cfg_p = '0;
    logic [CW-1:0] n_filter = '0, n_ifmap = '0, n_ipsum = '0, n_opsum = '0;
    logic          ctrl_busy, done, pe_enable, pe_configure;
    logic [3:0]    pe_S;
    logic [5:0]    pe_F;
    logic [2:0]    pe_U, pe_n, pe_q;
    logic [4:0]    pe_p;
    logic          pe_busy = 1'b0;
    logic          filter_valid = 1'b0, filter_ready, push_filter, filter_fifo_full = 1'b0;
    logic          ifmap_valid = 1'b0, ifmap_ready, push_ifmap, ifmap_fifo_full = 1'b0;
    logic          ipsum_valid = 1'b0, ipsum_ready, push_ipsum, ipsum_fifo_full = 1'b0;
    logic          opsum_fifo_empty = 1'b1, pop_opsum, opsum_valid, opsum_ready = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    pe_pass_controller dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_S(cfg_S), .cfg_F(cfg_F), .cfg_U(cfg_U), .cfg_n(cfg_n), .cfg_p(cfg_p), .cfg_q(cfg_q),
        .n_filter(n_filter), .n_ifmap(n_ifmap), .n_ipsum(n_ipsum), .n_opsum(n_opsum),
        .ctrl_busy(ctrl_busy), .done(done), .pe_enable(pe_enable), .pe_configure(pe_configure),
        .pe_S(pe_S), .pe_F(pe_F), .pe_U(pe_U), .pe_n(pe_n), .pe_p(pe_p), .pe_q(pe_q),
        .pe_busy(pe_busy),
        .filter_valid(filter_valid), .filter_ready(filter_ready), .push_filter(push_filter),
        .filter_fifo_full(filter_fifo_full),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .push_ifmap(push_ifmap),
        .ifmap_fifo_full(ifmap_fifo_full),
        .ipsum_valid(ipsum_valid), .ipsum_ready(ipsum_ready), .push_ipsum(push_ipsum),
        .ipsum_fifo_full(ipsum_fifo_full),
        .opsum_fifo_empty(opsum_fifo_empty), .pop_opsum(pop_opsum), .opsum_valid(opsum_valid),
        .opsum_ready(opsum_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {24'd0, push_filter, filter_ready, push_ifmap, ifmap_ready,
                  push_ipsum, ipsum_ready, pop_opsum, opsum_valid}, 32'd0);
    endtask

    task automatic drive_all_on();
        filter_valid = 1'b1; ifmap_valid = 1'b1; ipsum_valid = 1'b1;
        filter_fifo_full = 1'b0; ifmap_fifo_full = 1'b0; ipsum_fifo_full = 1'b0;
        opsum_fifo_empty = 1'b0; opsum_ready = 1'b1;
    endtask

    task automatic drive_random();
        filter_valid = ($urandom % 4) != 0; ifmap_valid = ($urandom % 4) != 0;
        ipsum_valid  = ($urandom % 4) != 0;
        filter_fifo_full = ($urandom % 4) == 0; ifmap_fifo_full = ($urandom % 4) == 0;
        ipsum_fifo_full  = ($urandom % 4) == 0;
        opsum_fifo_empty = ($urandom % 4) == 0; opsum_ready = ($urandom % 4) != 0;
    endtask

    // One complete pass; call right after step() while the DUT is idle.
    task automatic run_pass(input int nf, input int ni, input int np, input int no,
                            input int busy_cyc, input bit full_hold, input bit rnd);
        logic [23:0] cfg_exp;
        int rem_f, rem_i, rem_p, rem_o, act_f, act_i, act_p, act_o;
        bit ef, ei, ep, eov, eop, last;
        cfg_S = 4'($urandom); cfg_F = 6'($urandom); cfg_U = 3'($urandom);
        cfg_n = 3'($urandom); cfg_p = 5'($urandom); cfg_q = 3'($urandom);
        cfg_exp = {cfg_S, cfg_F, cfg_U, cfg_n, cfg_p, cfg_q};
        n_filter = CW'(nf); n_ifmap = CW'(ni); n_ipsum = CW'(np); n_opsum = CW'(no);
        start = 1'b1; abort = 1'b0; pe_busy = 1'b0;
        drive_all_on();
        #2;
        chk("idle_busy", 32'(ctrl_busy), 32'd0);
        chk_quiet("idle_quiet");
        step();
        start = 1'b0;
        cfg_S = ~cfg_S; cfg_F = ~cfg_F; cfg_q = ~cfg_q;
        n_filter = 16'hFFFF; n_ifmap = 16'hFFFF; n_ipsum = 16'hFFFF; n_opsum = 16'hFFFF;
        #2;
        chk("cfg_configure", 32'(pe_configure), 32'd1);
        chk("cfg_enable", 32'(pe_enable), 32'd1);
        chk("cfg_busy", 32'(ctrl_busy), 32'd1);
        chk("cfg_latched", 32'({pe_S, pe_F, pe_U, pe_n, pe_p, pe_q}), 32'(cfg_exp));
        chk_quiet("cfg_quiet");
        rem_f = nf; rem_i = ni; rem_p = np; rem_o = no;
        act_f = 0; act_i = 0; act_p = 0; act_o = 0;
        for (int k = 0; k < 4000; k++) begin
            step();
            if (rnd) drive_random(); else drive_all_on();
            if (full_hold && k < 5) begin
                filter_valid = 1'b1; filter_fifo_full = 1'b1;
            end
            start = 1'($urandom); pe_busy = 1'($urandom);
            #2;
            ef  = filter_valid && !filter_fifo_full && rem_f > 0;
            ei  = ifmap_valid && !ifmap_fifo_full && rem_i > 0;
            ep  = ipsum_valid && !ipsum_fifo_full && rem_p > 0;
            eov = !opsum_fifo_empty && rem_o > 0;
            eop = eov && opsum_ready;
            chk("stream_filter", 32'({push_filter, filter_ready}), 32'({ef, ef}));
            chk("stream_ifmap", 32'({push_ifmap, ifmap_ready}), 32'({ei, ei}));
            chk("stream_ipsum", 32'({push_ipsum, ipsum_ready}), 32'({ep, ep}));
            chk("stream_opsum", 32'({opsum_valid, pop_opsum}), 32'({eov, eop}));
            chk("stream_ctrl", 32'({pe_enable, pe_configure, done, ctrl_busy}), 32'(4'b1001));
            act_f += int'(push_filter); act_i += int'(push_ifmap);
            act_p += int'(push_ipsum);  act_o += int'(pop_opsum);
            last = (rem_f == 0) && (rem_i == 0) && (rem_p == 0) && (rem_o == 0);
            rem_f -= int'(ef); rem_i -= int'(ei); rem_p -= int'(ep); rem_o -= int'(eop);
            if (last) break;
        end
        for (int b = 0; b <= busy_cyc; b++) begin
            step();
            drive_random();
            start = 1'($urandom);
            pe_busy = (b < busy_cyc);
            #2;
            chk("wait_ctrl", 32'({pe_enable, done, ctrl_busy}), 32'(3'b101));
            chk_quiet("wait_quiet");
        end
        step();
        start = 1'b0; pe_busy = 1'($urandom);
        #2;
        chk("done_ctrl", 32'({done, pe_enable, ctrl_busy}), 32'(3'b101));
        chk("done_cfg_stable", 32'({pe_S, pe_F, pe_U, pe_n, pe_p, pe_q}), 32'(cfg_exp));
        chk_quiet("done_quiet");
        step();
        #2;
        chk("post_done", 32'({done, ctrl_busy, pe_enable}), 32'd0);
        chk("count_filter", 32'(act_f), 32'(nf));
        chk("count_ifmap", 32'(act_i), 32'(ni));
        chk("count_ipsum", 32'(act_p), 32'(np));
        chk("count_opsum", 32'(act_o), 32'(no));
    endtask

    initial begin
        #2;
        chk("reset_ctrl", 32'({ctrl_busy, done, pe_enable, pe_configure}), 32'd0);
        chk("reset_cfg", 32'({pe_S, pe_F, pe_U, pe_n, pe_p, pe_q}), 32'd0);
        chk_quiet("reset_quiet");
        @(posedge clk);
        #1 reset = 1'b1;

        step(); run_pass(3, 2, 1, 2, 0, 1'b0, 1'b0);
        step(); run_pass(3, 2, 1, 2, 0, 1'b1, 1'b0);
        step(); run_pass(0, 0, 0, 0, 0, 1'b0, 1'b0);
        step(); run_pass(3, 2, 1, 2, 10, 1'b0, 1'b1);

        // abort in IDLE wins over start
        step();
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        #2;
        chk("idle_abort", 32'({ctrl_busy, pe_configure}), 32'd0);

        // abort mid-stream after a single filter push
        step();
        n_filter = 16'd4; n_ifmap = 16'd4; n_ipsum = 16'd4; n_opsum = 16'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        filter_valid = 1'b1; filter_fifo_full = 1'b0;
        ifmap_valid = 1'b0; ipsum_valid = 1'b0; opsum_fifo_empty = 1'b1;
        #2;
        chk("abort_pre_push", 32'(push_filter), 32'd1);
        step();
        abort = 1'b1;
        drive_all_on();
        #2;
        chk_quiet("abort_cycle_quiet");
        step();
        abort = 1'b0;
        #2;
        chk("abort_next", 32'({ctrl_busy, pe_enable, done}), 32'd0);
        chk_quiet("abort_next_quiet");
        step();
        #2;
        chk("abort_no_done", 32'(done), 32'd0);
        step(); run_pass(3, 2, 1, 2, 0, 1'b0, 1'b0);

        // asynchronous reset mid-stream
        step();
        n_filter = 16'd5; n_ifmap = 16'd5; n_ipsum = 16'd5; n_opsum = 16'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        drive_all_on();
        #2;
        chk("rst_pre_push", 32'(push_filter), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rst_async_ctrl", 32'({ctrl_busy, done, pe_enable, pe_configure}), 32'd0);
        chk("rst_async_cfg", 32'({pe_S, pe_F, pe_U, pe_n, pe_p, pe_q}), 32'd0);
        chk_quiet("rst_async_quiet");
        #2 reset = 1'b1;
        step(); run_pass(2, 1, 3, 1, 0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            step();
            run_pass(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 3)), 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
